// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, the AxSIZE helper and the burst master state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_1  = 3'd0;
    localparam logic [2:0] SIZE_2  = 3'd1;
    localparam logic [2:0] SIZE_4  = 3'd2;
    localparam logic [2:0] SIZE_8  = 3'd3;
    localparam logic [2:0] SIZE_16 = 3'd4;

    // Bus width in bits -> AxSIZE encoding (bytes per beat as log2).
    function automatic logic [2:0] size_of(input int width);
        logic [2:0] size;
        case (width)
            8:       size = SIZE_1;
            16:      size = SIZE_2;
            32:      size = SIZE_4;
            64:      size = SIZE_8;
            128:     size = SIZE_16;
            default: size = SIZE_4;
        endcase
        return size;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RDATA
    } burst_state_t;

endpackage

// File: rtl/axi_beat_gen.sv
// Beat counter and incrementing data pattern shared by the write and read paths.
module axi_beat_gen #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    input  logic [7:0]        len,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    logic [DATA_W-1:0] pattern;
    logic [7:0]        idx;
    logic [7:0]        len_q;

    // Restart on a new command, then step pattern and index once per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
            idx     <= '0;
            len_q   <= '0;
        end else if (load) begin
            pattern <= seed;
            idx     <= '0;
            len_q   <= len;
        end else if (advance) begin
            pattern <= pattern + DATA_W'(1);
            idx     <= idx + 8'd1;
        end
    end

    assign data = pattern;
    assign last = (idx == len_q);

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst master: one write (AW/W/B) or read (AR/R) burst per accepted
// command, writing seed+i and checking reads against the same pattern.
module axi4_burst_master
    import axi_pkg::*;
#(
    parameter int C_ADDR_WIDTH   = 32,
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_ID_WIDTH     = 1,
    parameter int C_ERRCNT_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ID_WIDTH-1:0]     cmd_id,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [C_DATA_WIDTH-1:0]   cmd_seed,
    input  logic [7:0]                cmd_bwait,
    output logic                      done,
    output logic                      resp_err,
    output logic [C_ERRCNT_WIDTH-1:0] mismatch_cnt,
    input  logic                      err_clr,

    output logic [C_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,

    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,

    input  logic [C_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,

    output logic [C_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                M_AXI_ARLEN,
    output logic [2:0]                M_AXI_ARSIZE,
    output logic [1:0]                M_AXI_ARBURST,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,

    input  logic [C_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RLAST,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [2:0] AXSIZE = size_of(C_DATA_WIDTH);

    burst_state_t state;
    burst_state_t state_next;

    logic [C_ID_WIDTH-1:0]   id_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]              len_q;
    logic [7:0]              bwait_q;
    logic [7:0]              wait_cnt;
    logic                    aw_done;
    logic                    w_done;

    logic                    cmd_fire;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    aw_ok;
    logic                    w_ok;
    logic                    r_end;
    logic                    resp_evt;
    logic                    mismatch_evt;
    logic [C_DATA_WIDTH-1:0] beat_data;
    logic                    beat_last;
    logic                    unused_ids;

    // Response IDs are not checked; only one burst is ever in flight.
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

    assign cmd_fire = cmd_valid && (state == IDLE);
    assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs     = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs     = M_AXI_RVALID && M_AXI_RREADY;

    // AW and W complete independently; either may finish first.
    assign aw_ok = aw_done || aw_hs;
    assign w_ok  = w_done || (w_hs && beat_last);

    // A read ends on RLAST, or on the final expected beat if RLAST never shows.
    assign r_end = r_hs && (M_AXI_RLAST || beat_last);

    assign resp_evt = (b_hs && (M_AXI_BRESP != RESP_OKAY)) ||
                      (r_hs && ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != beat_last)));
    assign mismatch_evt = r_hs && (M_AXI_RDATA != beat_data);

    axi_beat_gen #(
        .DATA_W (C_DATA_WIDTH)
    ) u_beat_gen (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .load    (cmd_fire),
        .advance (w_hs || r_hs),
        .seed    (cmd_seed),
        .len     (cmd_len),
        .data    (beat_data),
        .last    (beat_last)
    );

    // Capture the command fields so the bus payload stays stable for the whole burst.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            bwait_q <= '0;
        end else if (cmd_fire) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            bwait_q <= cmd_bwait;
        end
    end

    // Remember which of the AW and WLAST handshakes has already happened.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (cmd_fire) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs && beat_last) begin
                w_done <= 1'b1;
            end
        end
    end

    // Delay counter for BREADY; it sits at bwait once the wait has elapsed.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wait_cnt <= '0;
        end else if (cmd_fire) begin
            wait_cnt <= '0;
        end else if ((state == WRESP) && (wait_cnt != bwait_q)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (cmd_valid) state_next = cmd_write ? WADDR_DATA : RADDR;
            WADDR_DATA: if (aw_ok && w_ok) state_next = WRESP;
            WRESP:      if (b_hs) state_next = IDLE;
            RADDR:      if (ar_hs) state_next = RDATA;
            RDATA:      if (r_end) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Bus outputs decoded from the state; payloads read zero outside their phase.
    always_comb begin
        cmd_ready     = 1'b0;
        M_AXI_AWID    = '0;
        M_AXI_AWADDR  = '0;
        M_AXI_AWLEN   = '0;
        M_AXI_AWSIZE  = '0;
        M_AXI_AWBURST = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WDATA   = '0;
        M_AXI_WSTRB   = '0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARID    = '0;
        M_AXI_ARADDR  = '0;
        M_AXI_ARLEN   = '0;
        M_AXI_ARSIZE  = '0;
        M_AXI_ARBURST = '0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            WADDR_DATA: begin
                M_AXI_AWID    = id_q;
                M_AXI_AWADDR  = addr_q;
                M_AXI_AWLEN   = len_q;
                M_AXI_AWSIZE  = AXSIZE;
                M_AXI_AWBURST = BURST_INCR;
                M_AXI_AWVALID = !aw_done;
                M_AXI_WDATA   = beat_data;
                M_AXI_WSTRB   = '1;
                M_AXI_WLAST   = beat_last;
                M_AXI_WVALID  = !w_done;
            end
            WRESP: begin
                M_AXI_BREADY = (wait_cnt == bwait_q);
            end
            RADDR: begin
                M_AXI_ARID    = id_q;
                M_AXI_ARADDR  = addr_q;
                M_AXI_ARLEN   = len_q;
                M_AXI_ARSIZE  = AXSIZE;
                M_AXI_ARBURST = BURST_INCR;
                M_AXI_ARVALID = 1'b1;
            end
            RDATA: begin
                M_AXI_RREADY = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // One-cycle completion pulse the cycle after the final handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            done <= 1'b0;
        end else begin
            done <= ((state == WRESP) && b_hs) || ((state == RDATA) && r_end);
        end
    end

    // Sticky error flag and saturating mismatch count; a clear beats a same-cycle error.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            resp_err     <= 1'b0;
            mismatch_cnt <= '0;
        end else if (err_clr) begin
            resp_err     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (resp_evt) begin
                resp_err <= 1'b1;
            end
            if (mismatch_evt && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + C_ERRCNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master with a stalling AXI slave model.
module tb_axi4_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [0:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_seed = '0;
    logic [7:0]  cmd_bwait = '0;
    logic        done;
    logic        resp_err;
    logic [15:0] mismatch_cnt;
    logic        err_clr = 1'b0;

    logic [0:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [0:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [0:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int vectors = 0;
    int miscompares = 0;

    // slave configuration
    int          stall_pct = 30;
    bit          hold_aw = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [31:0] r_seed = '0;
    int          r_corrupt = -1;
    int          r_slverr = -1;
    bit          r_drop_last = 1'b0;

    // slave observations
    int          cyc = 0;
    bit          aw_seen;
    logic [31:0] aw_addr_log;
    logic [7:0]  aw_len_log;
    logic [2:0]  aw_size_log;
    logic [1:0]  aw_burst_log;
    logic [0:0]  aw_id_log;
    int          w_beats;
    logic [31:0] w_data_log [0:15];
    int          w_last_idx;
    bit          w_done_s;
    bit          strb_ok;
    int          wa_cyc;
    int          bready_cyc;
    bit          b_done;
    bit          ar_seen;
    logic [31:0] ar_addr_log;
    logic [7:0]  ar_len_log;
    logic [2:0]  ar_size_log;
    logic [1:0]  ar_burst_log;
    logic [0:0]  ar_id_log;
    int          r_beat;

    logic [31:0] exp_t1 [0:4] = '{32'h12345678, 32'h12345679, 32'h1234567A, 32'h1234567B, 32'h1234567C};
    logic [31:0] exp_t3 [0:3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    always #5 ACLK = ~ACLK;

    axi4_burst_master dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_id        (cmd_id),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .cmd_bwait     (cmd_bwait),
        .done          (done),
        .resp_err      (resp_err),
        .mismatch_cnt  (mismatch_cnt),
        .err_clr       (err_clr),
        .M_AXI_AWID    (awid),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BID     (bid),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARID    (arid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RID     (rid),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearSlave();
        aw_seen    = 1'b0;
        w_beats    = 0;
        w_last_idx = -1;
        w_done_s   = 1'b0;
        strb_ok    = 1'b1;
        wa_cyc     = -1;
        bready_cyc = -1;
        b_done     = 1'b0;
        ar_seen    = 1'b0;
        r_beat     = 0;
        for (int i = 0; i < 16; i++) w_data_log[i] = '0;
    endtask

    // AXI slave: sample handshakes at the falling edge, update drives just after the rising edge.
    initial begin
        bit aw_h, w_h, b_h, ar_h, r_h;
        clearSlave();
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
                rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0; bresp = '0;
                continue;
            end
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            b_h  = bvalid && bready;
            ar_h = arvalid && arready;
            r_h  = rvalid && rready;
            if (aw_h) begin
                aw_seen = 1'b1; aw_addr_log = awaddr; aw_len_log = awlen;
                aw_size_log = awsize; aw_burst_log = awburst; aw_id_log = awid;
                wa_cyc = cyc;
            end
            if (w_h) begin
                if (w_beats < 16) w_data_log[w_beats] = wdata;
                if (wstrb !== 4'hF) strb_ok = 1'b0;
                if (wlast && !w_done_s) begin
                    w_done_s = 1'b1; w_last_idx = w_beats; wa_cyc = cyc;
                end
                w_beats++;
            end
            if (bready && bready_cyc < 0) bready_cyc = cyc;
            if (b_h) b_done = 1'b1;
            if (ar_h) begin
                ar_seen = 1'b1; ar_addr_log = araddr; ar_len_log = arlen;
                ar_size_log = arsize; ar_burst_log = arburst; ar_id_log = arid;
            end
            if (r_h) r_beat++;
            @(posedge ACLK);
            cyc++;
            #1;
            if (!ARESETN) continue;
            awready = (hold_aw && !w_done_s) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            wready  = ($urandom_range(99) >= stall_pct);
            arready = ($urandom_range(99) >= stall_pct);
            if (b_h) begin
                bvalid = 1'b0;
            end else if (!bvalid && aw_seen && w_done_s && !b_done && ($urandom_range(99) >= stall_pct)) begin
                bvalid = 1'b1; bresp = cfg_bresp; bid = aw_id_log;
            end
            if (!(rvalid && !r_h)) begin
                if (ar_seen && r_beat <= int'(ar_len_log) && ($urandom_range(99) >= stall_pct)) begin
                    rvalid = 1'b1;
                    rid    = ar_id_log;
                    rdata  = r_seed + 32'(r_beat);
                    if (r_beat == r_corrupt) rdata = rdata ^ 32'h0000_0100;
                    rresp  = (r_beat == r_slverr) ? 2'b10 : 2'b00;
                    rlast  = (r_beat == int'(ar_len_log)) && !r_drop_last;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0;
                end
            end
        end
    end

    task automatic issueCmd(input bit wr, input logic [0:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [31:0] seed, input logic [7:0] bwait);
        clearSlave();
        @(posedge ACLK);
        #1;
        cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_seed = seed; cmd_bwait = bwait; cmd_valid = 1'b1;
        @(negedge ACLK);
        checkOutput("cmd_ready", cmd_ready, 1'b1);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        checkOutput(wr ? "awvalid_latency" : "arvalid_latency", wr ? awvalid : arvalid, 1'b1);
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge ACLK);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_done"}, seen, 1'b1);
        if (seen) begin
            @(negedge ACLK);
            checkOutput({tag, "_done_pulse"}, done, 1'b0);
            checkOutput({tag, "_idle"}, cmd_ready, 1'b1);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit wr, input logic [0:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [31:0] seed, input logic [7:0] bwait);
        issueCmd(wr, id, addr, len, seed, bwait);
        waitDone(tag);
    endtask

    task automatic pulseErrClr();
        @(posedge ACLK);
        #1 err_clr = 1'b1;
        @(posedge ACLK);
        #1 err_clr = 1'b0;
        @(negedge ACLK);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge ACLK);
        checkOutput("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        checkOutput("rst_payload", {awaddr, awlen, awsize, awburst, wdata, wstrb, wlast}, '0);
        checkOutput("rst_status", {done, resp_err, mismatch_cnt}, '0);
        #3 ARESETN = 1'b1;

        // incrementing write burst
        applyStimulus("wr_len4", 1'b1, 1'b1, 32'h100, 8'd4, 32'h12345678, 8'd0);
        checkOutput("wr_len4_beats", w_beats, 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("wr_len4_wdata%0d", i), w_data_log[i], exp_t1[i]);
        checkOutput("wr_len4_wlast_idx", w_last_idx, 4);
        checkOutput("wr_len4_aw", {aw_id_log, aw_addr_log, aw_len_log, aw_size_log, aw_burst_log},
                    {1'b1, 32'h100, 8'd4, 3'd2, 2'b01});
        checkOutput("wr_len4_wstrb", strb_ok, 1'b1);
        checkOutput("wr_len4_resp_err", resp_err, 1'b0);

        // single beat write with a one-cycle BREADY delay
        applyStimulus("wr_len0", 1'b1, 1'b0, 32'h200, 8'd0, 32'hFFFFFFFF, 8'd1);
        checkOutput("wr_len0_beats", w_beats, 1);
        checkOutput("wr_len0_wdata", w_data_log[0], 32'hFFFFFFFF);
        checkOutput("wr_len0_wlast_idx", w_last_idx, 0);
        checkOutput("wr_len0_bready_delay", bready_cyc - wa_cyc, 2);

        // AWREADY withheld until all W beats are taken; pattern wraps past all-ones
        hold_aw = 1'b1;
        applyStimulus("wr_holdaw", 1'b1, 1'b0, 32'h300, 8'd3, 32'hFFFFFFFE, 8'd0);
        hold_aw = 1'b0;
        checkOutput("wr_holdaw_beats", w_beats, 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("wr_holdaw_wdata%0d", i), w_data_log[i], exp_t3[i]);
        checkOutput("wr_holdaw_awaddr", aw_addr_log, 32'h300);

        // clean read burst
        r_seed = 32'h12345678;
        applyStimulus("rd_clean", 1'b0, 1'b1, 32'h100, 8'd4, 32'h12345678, 8'd0);
        checkOutput("rd_clean_ar", {ar_id_log, ar_addr_log, ar_len_log, ar_size_log, ar_burst_log},
                    {1'b1, 32'h100, 8'd4, 3'd2, 2'b01});
        checkOutput("rd_clean_beats", r_beat, 5);
        checkOutput("rd_clean_mismatch", mismatch_cnt, 16'd0);
        checkOutput("rd_clean_resp_err", resp_err, 1'b0);

        // corrupted beat 2 and SLVERR on beat 3
        r_seed = 32'hA5A50000; r_corrupt = 2; r_slverr = 3;
        applyStimulus("rd_bad", 1'b0, 1'b0, 32'h400, 8'd4, 32'hA5A50000, 8'd0);
        checkOutput("rd_bad_mismatch", mismatch_cnt, 16'd1);
        checkOutput("rd_bad_resp_err", resp_err, 1'b1);
        pulseErrClr();
        checkOutput("err_clr_mismatch", mismatch_cnt, 16'd0);
        checkOutput("err_clr_resp_err", resp_err, 1'b0);

        // errors arriving while err_clr is held are discarded
        r_corrupt = 1; r_slverr = 0;
        #1 err_clr = 1'b1;
        applyStimulus("rd_clrwin", 1'b0, 1'b0, 32'h500, 8'd2, 32'hA5A50000, 8'd0);
        checkOutput("rd_clrwin_err", {resp_err, mismatch_cnt}, 17'd0);
        err_clr = 1'b0;
        r_corrupt = -1; r_slverr = -1;

        // missing RLAST still ends the burst and flags an error
        r_seed = 32'h00000040; r_drop_last = 1'b1;
        applyStimulus("rd_nolast", 1'b0, 1'b0, 32'h600, 8'd2, 32'h00000040, 8'd0);
        r_drop_last = 1'b0;
        checkOutput("rd_nolast_beats", r_beat, 3);
        checkOutput("rd_nolast_err", {resp_err, mismatch_cnt}, {1'b1, 16'd0});
        pulseErrClr();

        // SLVERR write response
        cfg_bresp = 2'b10;
        applyStimulus("wr_slverr", 1'b1, 1'b0, 32'h700, 8'd1, 32'h00000010, 8'd2);
        cfg_bresp = 2'b00;
        checkOutput("wr_slverr_resp_err", resp_err, 1'b1);
        checkOutput("wr_slverr_bready_delay", bready_cyc - wa_cyc, 3);
        pulseErrClr();

        // reset in the middle of a write burst
        stall_pct = 50;
        issueCmd(1'b1, 1'b0, 32'h800, 8'd7, 32'h00000020, 8'd0);
        @(posedge ACLK);
        #2;
        checkOutput("abort_busy", wvalid, 1'b1);
        #1 ARESETN = 1'b0;
        #1;
        checkOutput("abort_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        repeat (2) @(posedge ACLK);
        #3 ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        checkOutput("abort_no_resume", {awvalid, wvalid, arvalid, cmd_ready}, 4'b0001);
        stall_pct = 30;
        applyStimulus("wr_after_rst", 1'b1, 1'b0, 32'h900, 8'd1, 32'h00000010, 8'd0);
        checkOutput("wr_after_rst_data", {w_data_log[0], w_data_log[1]}, {32'h00000010, 32'h00000011});
        checkOutput("wr_after_rst_awaddr", aw_addr_log, 32'h900);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
